// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-sharing scheduler: function codes, CCR bit
// positions, FSM encoding, issue payload and per-function flag-update mask.
package alu_pkg;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned FUNC_W = 4;
  localparam int unsigned FLAG_W = 3;

  localparam logic [FUNC_W-1:0] ALU_NOP  = 4'h0;
  localparam logic [FUNC_W-1:0] ALU_SETC = 4'h1;
  localparam logic [FUNC_W-1:0] ALU_CLRC = 4'h2;
  localparam logic [FUNC_W-1:0] ALU_MOV  = 4'h3;
  localparam logic [FUNC_W-1:0] ALU_NOT  = 4'h4;
  localparam logic [FUNC_W-1:0] ALU_XOR  = 4'h5;
  localparam logic [FUNC_W-1:0] ALU_INC  = 4'h6;
  localparam logic [FUNC_W-1:0] ALU_DEC  = 4'h7;
  localparam logic [FUNC_W-1:0] ALU_ADD  = 4'h8;
  localparam logic [FUNC_W-1:0] ALU_SUB  = 4'h9;
  localparam logic [FUNC_W-1:0] ALU_AND  = 4'hA;
  localparam logic [FUNC_W-1:0] ALU_OR   = 4'hB;
  localparam logic [FUNC_W-1:0] ALU_SHL  = 4'hC;
  localparam logic [FUNC_W-1:0] ALU_SHR  = 4'hD;

  localparam int unsigned FLG_Z = 0;
  localparam int unsigned FLG_N = 1;
  localparam int unsigned FLG_C = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EXEC = 1'b1
  } state_e;

  typedef struct packed {
    logic              id;
    logic [FUNC_W-1:0] func;
    logic [WIDTH-1:0]  op2;
    logic [WIDTH-1:0]  op1;
  } issue_t;

  // CCR bits loaded from the ALU flags for each function; SETC/CLRC handled separately.
  function automatic logic [FLAG_W-1:0] flag_mask(input logic [FUNC_W-1:0] func);
    logic [FLAG_W-1:0] m;
    m = '0;
    case (func)
      ALU_MOV, ALU_NOT, ALU_XOR, ALU_AND, ALU_OR: m = 3'b011;
      ALU_INC, ALU_DEC, ALU_ADD, ALU_SUB, ALU_SHL, ALU_SHR: m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational grant, last-grant pointer moves
// only on a completed handshake.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] i_req,
  input  logic       i_en,
  output logic [1:0] o_gnt_c
);

  logic r_last;

  always_comb begin
    o_gnt_c = 2'b00;
    if (i_en) begin
      case (i_req)
        2'b01:   o_gnt_c = 2'b01;
        2'b10:   o_gnt_c = 2'b10;
        2'b11:   o_gnt_c = r_last ? 2'b01 : 2'b10;
        default: o_gnt_c = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (|(i_req & o_gnt_c)) begin
      r_last <= o_gnt_c[1];
    end
  end

endmodule

// File: rtl/alu_share_sched.sv
// Time-shares one 16-bit ALU between the execute stage (port 0) and the
// interrupt/call unit (port 1); returns tagged results and owns the CCR.
module alu_share_sched
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [WIDTH-1:0]  op1_0,
  input  logic [WIDTH-1:0]  op1_1,
  input  logic [WIDTH-1:0]  op2_0,
  input  logic [WIDTH-1:0]  op2_1,
  input  logic [FUNC_W-1:0] func_0,
  input  logic [FUNC_W-1:0] func_1,
  output logic              gnt0,
  output logic              gnt1,
  output logic [WIDTH-1:0]  alu_op1,
  output logic [WIDTH-1:0]  alu_op2,
  output logic [FUNC_W-1:0] alu_func,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [WIDTH-1:0]  alu_flags,
  output logic              rsp_valid,
  output logic              rsp_id,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [WIDTH-1:0]  ccr,
  input  logic              flag_restore,
  input  logic [WIDTH-1:0]  flag_restore_val
);

  state_e            r_state;
  logic              r_id;
  logic [WIDTH-1:0]  r_alu_op1;
  logic [WIDTH-1:0]  r_alu_op2;
  logic [FUNC_W-1:0] r_alu_func;
  logic              r_rsp_valid;
  logic              r_rsp_id;
  logic [WIDTH-1:0]  r_rsp_result;
  logic [FLAG_W-1:0] r_ccr;

  logic [1:0]        w_gnt;
  logic              w_idle;
  logic              w_hs;
  issue_t            w_win;
  logic [FLAG_W-1:0] w_mask;
  logic [FLAG_W-1:0] w_ccr_nxt;
  logic              w_unused_bits;

  assign w_idle = (r_state == ST_IDLE);

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .i_req   ({req1, req0}),
    .i_en    (w_idle),
    .o_gnt_c (w_gnt)
  );

  assign w_hs = |({req1, req0} & w_gnt);

  // Operand mux for whichever port holds the grant.
  always_comb begin
    w_win = '{id: 1'b0, func: func_0, op2: op2_0, op1: op1_0};
    if (w_gnt[1]) begin
      w_win = '{id: 1'b1, func: func_1, op2: op2_1, op1: op1_1};
    end
  end

  always_comb begin
    w_mask    = flag_mask(r_alu_func);
    w_ccr_nxt = (r_ccr & ~w_mask) | (alu_flags[FLAG_W-1:0] & w_mask);
    if (r_alu_func == ALU_SETC) w_ccr_nxt[FLG_C] = 1'b1;
    if (r_alu_func == ALU_CLRC) w_ccr_nxt[FLG_C] = 1'b0;
  end

  // Upper flag/restore bits are not architected.
  assign w_unused_bits = ^{alu_flags[WIDTH-1:FLAG_W], flag_restore_val[WIDTH-1:FLAG_W]};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_id         <= 1'b0;
      r_alu_op1    <= '0;
      r_alu_op2    <= '0;
      r_alu_func   <= ALU_NOP;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_ccr        <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_hs) begin
            r_alu_op1  <= w_win.op1;
            r_alu_op2  <= w_win.op2;
            r_alu_func <= w_win.func;
            r_id       <= w_win.id;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_rsp_valid  <= 1'b1;
          r_rsp_id     <= r_id;
          r_rsp_result <= alu_result;
          r_alu_func   <= ALU_NOP;
          r_state      <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
      // A restore overrides any flag update from the op finishing this cycle.
      if (flag_restore) begin
        r_ccr <= flag_restore_val[FLAG_W-1:0];
      end else if (r_state == ST_EXEC) begin
        r_ccr <= w_ccr_nxt;
      end
    end
  end

  assign gnt0       = w_gnt[0];
  assign gnt1       = w_gnt[1];
  assign alu_op1    = r_alu_op1;
  assign alu_op2    = r_alu_op2;
  assign alu_func   = r_alu_func;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign ccr        = WIDTH'(r_ccr);

endmodule

// File: tb/tb_alu_share_sched.sv
// Directed scoreboard bench for alu_share_sched with a behavioural ALU model.
module tb_alu_share_sched;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1;
  logic [15:0] op1_0, op1_1, op2_0, op2_1;
  logic [3:0]  func_0, func_1;
  logic        gnt0, gnt1;
  logic [15:0] alu_op1, alu_op2;
  logic [3:0]  alu_func;
  logic [15:0] alu_result, alu_flags;
  logic        rsp_valid, rsp_id;
  logic [15:0] rsp_result, ccr;
  logic        flag_restore;
  logic [15:0] flag_restore_val;

  typedef struct {
    logic        id;
    logic [15:0] res;
    logic [15:0] ccr;
  } exp_t;

  exp_t q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  alu_share_sched dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1),
    .op1_0(op1_0), .op1_1(op1_1), .op2_0(op2_0), .op2_1(op2_1),
    .func_0(func_0), .func_1(func_1), .gnt0(gnt0), .gnt1(gnt1),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_func(alu_func),
    .alu_result(alu_result), .alu_flags(alu_flags),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .ccr(ccr),
    .flag_restore(flag_restore), .flag_restore_val(flag_restore_val)
  );

  // Behavioural ALU: ADD/SUB/AND only; upper flag bits driven high so leakage shows.
  logic [16:0] alu_sum;
  logic        alu_c;
  assign alu_sum = {1'b0, alu_op1} + {1'b0, alu_op2};
  always_comb begin
    alu_result = 16'h0000;
    alu_c      = 1'b0;
    case (alu_func)
      4'h8: begin alu_result = alu_sum[15:0]; alu_c = alu_sum[16]; end
      4'h9: begin alu_result = alu_op1 - alu_op2; alu_c = (alu_op1 < alu_op2); end
      4'hA: alu_result = alu_op1 & alu_op2;
      default: alu_result = 16'h0000;
    endcase
    alu_flags = {13'h1FFF, alu_c, alu_result[15], (alu_result == 16'h0000)};
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rsp_valid === 1'b1) begin
      if (q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_rsp: got id %0d result %h expected none", rsp_id, rsp_result);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("rsp_id", 16'(rsp_id), 16'(e.id));
        check("rsp_result", rsp_result, e.res);
        check("ccr", ccr, e.ccr);
      end
    end
  end

  // mode 0: normal, 1: flag restore during EXEC, 2: reset during EXEC.
  task automatic issue(input int port, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] f, input logic [15:0] er, input logic [15:0] eccr,
                       input int mode);
    int waited;
    exp_t e;
    @(posedge clk); #1;
    if (port == 0) begin req0 = 1'b1; op1_0 = a; op2_0 = b; func_0 = f; end
    else           begin req1 = 1'b1; op1_1 = a; op2_1 = b; func_1 = f; end
    waited = 0;
    @(negedge clk);
    while (!((port == 0) ? gnt0 : gnt1) && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 20) begin
      n_total++;
      $display("FAIL grant_timeout: port %0d got no grant expected grant", port);
      req0 = 1'b0; req1 = 1'b0;
      return;
    end
    if (mode != 2) begin
      e.id = 1'(port); e.res = er; e.ccr = eccr;
      q.push_back(e);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    if (mode == 1) begin flag_restore = 1'b1; flag_restore_val = 16'hFFF2; end
    if (mode == 2) rst = 1'b1;
    @(negedge clk);
    check("exec_func", 16'(alu_func), 16'(f));
    check("exec_op1", alu_op1, a);
    check("exec_no_gnt", 16'({gnt1, gnt0}), 16'h0000);
    @(posedge clk); #1;
    flag_restore = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    check("rsp_valid_timing", 16'(rsp_valid), (mode == 2) ? 16'h0000 : 16'h0001);
    check("idle_func_nop", 16'(alu_func), 16'h0000);
    if (mode == 2) check("ccr_after_reset", ccr, 16'h0000);
  endtask

  logic exp_ord [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    exp_t e;
    int   k;
    int   cyc;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    op1_0 = '0; op1_1 = '0; op2_0 = '0; op2_1 = '0; func_0 = '0; func_1 = '0;
    flag_restore = 1'b0; flag_restore_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_gnt", 16'({gnt1, gnt0}), 16'h0000);
    check("rst_alu_func", 16'(alu_func), 16'h0000);
    check("rst_alu_op1", alu_op1, 16'h0000);
    check("rst_alu_op2", alu_op2, 16'h0000);
    check("rst_rsp_valid", 16'(rsp_valid), 16'h0000);
    check("rst_rsp_result", rsp_result, 16'h0000);
    check("rst_ccr", ccr, 16'h0000);
    @(posedge clk); #1 rst = 1'b0;

    // Basic ADD, then carry/zero ADD and AND keeping C.
    issue(0, 16'h0003, 16'h0004, 4'h8, 16'h0007, 16'h0000, 0);
    issue(1, 16'hFFFF, 16'h0001, 4'h8, 16'h0000, 16'h0005, 0);
    issue(1, 16'h8000, 16'hFFFF, 4'hA, 16'h8000, 16'h0006, 0);

    // Both ports held: grants must alternate, none while executing.
    @(posedge clk); #1;
    req0 = 1'b1; op1_0 = 16'd5; op2_0 = 16'd5; func_0 = 4'h9;
    req1 = 1'b1; op1_1 = 16'd5; op2_1 = 16'd5; func_1 = 4'h9;
    k = 0; cyc = 0;
    while (k < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (gnt0 || gnt1) begin
        check("t2_order", 16'({gnt1, gnt0}), exp_ord[k] ? 16'h0002 : 16'h0001);
        e.id = exp_ord[k]; e.res = 16'h0000; e.ccr = 16'h0001;
        q.push_back(e);
        @(posedge clk); #1;
        k++;
        if (k == 4) begin req0 = 1'b0; req1 = 1'b0; end
        @(negedge clk);
        check("t2_no_gnt_exec", 16'({gnt1, gnt0}), 16'h0000);
      end
    end
    req0 = 1'b0; req1 = 1'b0;
    check("t2_grants_seen", 16'(k), 16'd4);

    // SETC then NOP.
    issue(0, 16'h1234, 16'h5678, 4'h1, 16'h0000, 16'h0005, 0);
    issue(1, 16'h1234, 16'h5678, 4'h0, 16'h0000, 16'h0005, 0);

    // Restore collides with a Z-producing ADD.
    issue(0, 16'h0000, 16'h0000, 4'h8, 16'h0000, 16'h0002, 1);

    // Reset mid-EXEC from port 0; port 0 must still win the next tie.
    issue(0, 16'h0009, 16'h0009, 4'h8, 16'h0012, 16'h0000, 2);
    @(posedge clk); #1;
    req0 = 1'b1; op1_0 = 16'd1; op2_0 = 16'd1; func_0 = 4'h8;
    req1 = 1'b1; op1_1 = 16'd7; op2_1 = 16'd7; func_1 = 4'h9;
    @(negedge clk);
    check("t6_first_gnt", 16'({gnt1, gnt0}), 16'h0001);
    if (gnt0) begin
      e.id = 1'b0; e.res = 16'h0002; e.ccr = 16'h0000;
      q.push_back(e);
    end
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;

    cyc = 0;
    while (q.size() != 0 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("drain", 16'(q.size()), 16'h0000);
    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
